autosa_csc_grp_ctrl: RTL and testbench

- Two-group (ping-pong) register-group sequencer for CSC; sits between the CSC single-register block and the CSC datapath.
- Consumes `producer` and the op_en write trigger, and tracks the per-group enable flags.
- Launches the datapath on the consumer group and retires the group on op_done.
- Returns `consumer`, `status_0` and `status_1` to the single-register block for software readback.

---
 rtl/autosa_csc_grp_pkg.sv | 30 +++
 rtl/autosa_csc_grp_drain_cnt.sv | 35 +++
 rtl/autosa_csc_grp_ctrl.sv | 136 +++++++++++++
 tb/tb_autosa_csc_grp_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/autosa_csc_grp_pkg.sv
// Shared types and constants for the CSC ping-pong register-group sequencer.
package autosa_csc_grp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_DBL_TRIG   = 2'd1;
  localparam logic [1:0] ERR_STRAY_DONE = 2'd2;

  // Software-visible status of one group from its enable flag and whether it owns the datapath.
  function automatic logic [1:0] grp_status(input logic en, input logic active);
    if (!en) begin
      return ST_IDLE;
    end
    if (active) begin
      return ST_RUNNING;
    end
    return ST_PENDING;
  endfunction

endpackage

// File: rtl/autosa_csc_grp_drain_cnt.sv
// Loadable down-counter with a zero flag; holds the datapath flush delay after op_done.
module autosa_csc_grp_drain_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             autosa_core_clk,
  input  logic             autosa_core_rstn,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/autosa_csc_grp_ctrl.sv
// Two-group ping-pong sequencer between the CSC single-register block and the CSC datapath.
// Optional error reporting (grp_err, grp_err_code) is enabled by defining AUTOSA_CSC_GRP_ERR_EN.
module autosa_csc_grp_ctrl
  import autosa_csc_grp_pkg::*;
#(
  parameter int DONE_DLY = 2,
  parameter int CNT_W    = 4
) (
  input  logic       autosa_core_clk,
  input  logic       autosa_core_rstn,
  input  logic       producer,
  input  logic       op_en_trigger,
  input  logic       op_done,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic       core_start,
  output logic       core_grp,
  output logic       core_busy
`ifdef AUTOSA_CSC_GRP_ERR_EN
  ,
  output logic       grp_err,
  output logic [1:0] grp_err_code
`endif
);

  state_t     state_q, state_d;
  logic [1:0] op_en_q, op_en_d;
  logic       consumer_q, consumer_d;
  logic       cnt_load, cnt_dec, cnt_zero, retire;
  logic [1:0] status_w [2];

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    retire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_en_q[consumer_q]) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = BUSY;
      BUSY: begin
        if (op_done) begin
          cnt_load = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          retire  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set is applied after the retirement clear so a same-cycle re-trigger leaves the group pending.
  always_comb begin
    op_en_d = op_en_q;
    if (retire) begin
      op_en_d[consumer_q] = 1'b0;
    end
    if (op_en_trigger) begin
      op_en_d[producer] = 1'b1;
    end
    consumer_d = consumer_q ^ retire;
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q    <= IDLE;
      op_en_q    <= 2'b00;
      consumer_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_en_q    <= op_en_d;
      consumer_q <= consumer_d;
    end
  end

  autosa_csc_grp_drain_cnt #(
    .CNT_W(CNT_W)
  ) u_drain_cnt (
    .autosa_core_clk (autosa_core_clk),
    .autosa_core_rstn(autosa_core_rstn),
    .load_i          (cnt_load),
    .load_val_i      (CNT_W'(DONE_DLY)),
    .dec_i           (cnt_dec),
    .zero_o          (cnt_zero)
  );

  assign core_start = (state_q == LAUNCH);
  assign core_busy  = (state_q != IDLE);
  assign consumer   = consumer_q;
  assign core_grp   = consumer_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_status
    assign status_w[gi] = grp_status(op_en_q[gi], (consumer_q == 1'(gi)) && core_busy);
  end

  assign status_0 = status_w[0];
  assign status_1 = status_w[1];

`ifdef AUTOSA_CSC_GRP_ERR_EN
  logic       grp_err_q;
  logic [1:0] grp_err_code_q;
  logic       dbl_trig, stray_done;

  assign dbl_trig   = op_en_trigger && op_en_q[producer];
  assign stray_done = op_done && (state_q != BUSY);

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      grp_err_q      <= 1'b0;
      grp_err_code_q <= ERR_NONE;
    end else begin
      grp_err_q <= dbl_trig || stray_done;
      if (dbl_trig) begin
        grp_err_code_q <= ERR_DBL_TRIG;
      end else if (stray_done) begin
        grp_err_code_q <= ERR_STRAY_DONE;
      end
    end
  end

  assign grp_err      = grp_err_q;
  assign grp_err_code = grp_err_code_q;
`endif

endmodule

// File: tb/tb_autosa_csc_grp_ctrl.sv
// Directed self-checking bench for autosa_csc_grp_ctrl (DONE_DLY=2); error outputs checked when AUTOSA_CSC_GRP_ERR_EN is defined.
module tb_autosa_csc_grp_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       producer;
  logic       op_en_trigger;
  logic       op_done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic       core_start;
  logic       core_grp;
  logic       core_busy;
`ifdef AUTOSA_CSC_GRP_ERR_EN
  logic       grp_err;
  logic [1:0] grp_err_code;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  autosa_csc_grp_ctrl #(
    .DONE_DLY(2),
    .CNT_W   (4)
  ) dut (
    .autosa_core_clk (clk),
    .autosa_core_rstn(rstn),
    .producer        (producer),
    .op_en_trigger   (op_en_trigger),
    .op_done         (op_done),
    .consumer        (consumer),
    .status_0        (status_0),
    .status_1        (status_1),
    .core_start      (core_start),
    .core_grp        (core_grp),
    .core_busy       (core_busy)
`ifdef AUTOSA_CSC_GRP_ERR_EN
    ,
    .grp_err         (grp_err),
    .grp_err_code    (grp_err_code)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    producer = 1'b0;
    op_en_trigger = 1'b0;
    op_done = 1'b0;
    step();
    step();
    chk("rst_consumer", consumer, 0);
    chk("rst_status_0", status_0, 0);
    chk("rst_status_1", status_1, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_busy", core_busy, 0);
`ifdef AUTOSA_CSC_GRP_ERR_EN
    chk("rst_grp_err", grp_err, 0);
    chk("rst_grp_err_code", grp_err_code, 0);
`endif
    rstn = 1'b1;
    step();

    // Trigger group 0 from idle: enable one edge later, launch the edge after.
    producer = 1'b0; op_en_trigger = 1'b1;
    step();
    op_en_trigger = 1'b0;
    chk("t1_start_early", core_start, 0);
    chk("t1_pending_s0", status_0, 2);
    chk("t1_busy_early", core_busy, 0);
    step();
    chk("t1_core_start", core_start, 1);
    chk("t1_core_grp", core_grp, 0);
    chk("t1_run_s0", status_0, 1);
    chk("t1_idle_s1", status_1, 0);
    chk("t1_busy", core_busy, 1);
    step();
    chk("t1_start_pulse", core_start, 0);
    chk("t1_busy_hold", core_busy, 1);

    // Queue group 1 while group 0 runs.
    producer = 1'b1; op_en_trigger = 1'b1;
    step();
    op_en_trigger = 1'b0;
    chk("t3_pending_s1", status_1, 2);
    chk("t3_run_s0", status_0, 1);

    // op_done then two drain cycles before retirement.
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("t2_drain_busy", core_busy, 1);
    chk("t2_drain_s0", status_0, 1);
    step();
    step();
    chk("t2_last_drain_cons", consumer, 0);
    chk("t2_last_drain_busy", core_busy, 1);
    step();
    chk("t2_retire_cons", consumer, 1);
    chk("t2_retire_grp", core_grp, 1);
    chk("t2_retire_s0", status_0, 0);
    chk("t2_retire_busy", core_busy, 0);
    chk("t3_idle_gap_start", core_start, 0);
    chk("t3_idle_gap_s1", status_1, 2);
    step();
    chk("t3_g1_start", core_start, 1);
    chk("t3_g1_grp", core_grp, 1);
    chk("t3_g1_run_s1", status_1, 1);
    step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    step();
    step();
    step();
    chk("t3_back_cons", consumer, 0);
    chk("t3_back_s1", status_1, 0);
    chk("t3_back_busy", core_busy, 0);
    step();
    chk("t3_no_relaunch", core_start, 0);

    // Re-trigger group 0 in the very cycle it retires.
    producer = 1'b0; op_en_trigger = 1'b1;
    step();
    op_en_trigger = 1'b0;
    step();
    chk("t4_g0_start", core_start, 1);
    step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    step();
    step();
    producer = 1'b0; op_en_trigger = 1'b1;
    step();
    op_en_trigger = 1'b0;
    chk("t4_retire_cons", consumer, 1);
    chk("t4_set_wins_s0", status_0, 2);
    chk("t4_retire_s1", status_1, 0);
    chk("t4_retire_busy", core_busy, 0);
    step();
    chk("t4_wait_g1_start", core_start, 0);
    chk("t4_wait_g1_cons", consumer, 1);
    producer = 1'b1; op_en_trigger = 1'b1;
    step();
    op_en_trigger = 1'b0;
    step();
    chk("t4_g1_start", core_start, 1);
    chk("t4_g1_grp", core_grp, 1);
    chk("t4_g1_s0", status_0, 2);
    chk("t4_g1_s1", status_1, 1);
    step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    step();
    step();
    step();
    chk("t4_second_cons", consumer, 0);
    chk("t4_second_s1", status_1, 0);
    chk("t4_second_s0", status_0, 2);
    chk("t4_second_busy", core_busy, 0);
    step();
    chk("t4_relaunch_start", core_start, 1);
    chk("t4_relaunch_grp", core_grp, 0);
    chk("t4_relaunch_s0", status_0, 1);

    // op_done during LAUNCH must not start a drain.
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("stray_busy", core_busy, 1);
`ifdef AUTOSA_CSC_GRP_ERR_EN
    chk("stray_grp_err", grp_err, 1);
    chk("stray_err_code", grp_err_code, 2);
`endif
    step();
`ifdef AUTOSA_CSC_GRP_ERR_EN
    chk("stray_err_pulse_end", grp_err, 0);
    chk("stray_err_code_held", grp_err_code, 2);
`endif
    step();
    step();
    step();
    chk("stray_still_busy", core_busy, 1);
    chk("stray_still_s0", status_0, 1);
    chk("stray_still_cons", consumer, 0);

    // Second trigger to the running group is ignored.
    producer = 1'b0; op_en_trigger = 1'b1;
    step();
    op_en_trigger = 1'b0;
    chk("dbl_s0", status_0, 1);
    chk("dbl_busy", core_busy, 1);
    chk("dbl_start", core_start, 0);
`ifdef AUTOSA_CSC_GRP_ERR_EN
    chk("dbl_grp_err", grp_err, 1);
    chk("dbl_err_code", grp_err_code, 1);
`endif

    // Asynchronous reset with group 0 busy and group 1 pending.
    producer = 1'b1; op_en_trigger = 1'b1;
    step();
    op_en_trigger = 1'b0;
    chk("t5_pre_s1", status_1, 2);
    rstn = 1'b0;
    #1;
    chk("t5_rst_cons", consumer, 0);
    chk("t5_rst_s0", status_0, 0);
    chk("t5_rst_s1", status_1, 0);
    chk("t5_rst_start", core_start, 0);
    chk("t5_rst_busy", core_busy, 0);
    chk("t5_rst_grp", core_grp, 0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_post_start_%0d", i), core_start, 0);
      chk($sformatf("t5_post_busy_%0d", i), core_busy, 0);
      chk($sformatf("t5_post_s1_%0d", i), status_1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
